lane_serializer: RTL and testbench

- Per-lane parallel-to-serial stage of phy_TX. Sits directly downstream of the byte-striping block and consumes one lane's 8-bit data_out_N / valid_N.
- Emits one bit per clock, MSB first.
- After reset, sends a fixed training burst of COM symbols. Afterwards it sends data bytes, or COM as the idle fill.
- One instance per lane.

---
 rtl/lane_serializer.sv | 85 ++++++++
 tb/tb_lane_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// Per-lane parallel-to-serial stage: MSB-first bit stream. A COM training burst
// follows reset, then data bytes or COM idle fill.
module lane_serializer #(
  parameter int unsigned SYNC_SYMS = 4,
  parameter logic [7:0]  COM       = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       active,
  output logic       load,
  output logic       data_out,
  output logic       valid_out,
  output logic       sync_done
);

  typedef enum logic {SYNC, DATA} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       is_data_q, is_data_d;
  logic       boundary;

  assign boundary = (cnt_q == 3'd7);

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      cnt_q      <= 3'd7;
      shreg_q    <= '0;
      sync_cnt_q <= '0;
      is_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      sync_cnt_q <= sync_cnt_d;
      is_data_q  <= is_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 3'd1;
    shreg_d    = {shreg_q[6:0], 1'b0};
    sync_cnt_d = sync_cnt_q;
    is_data_d  = is_data_q;
    if (boundary) begin
      unique case (state_q)
        SYNC: begin
          shreg_d   = COM;
          is_data_d = 1'b0;
          if (sync_cnt_q == 4'(SYNC_SYMS - 1)) begin
            state_d    = DATA;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end
        DATA: begin
          // Bytes offered while the link is inactive are dropped, not held.
          if (valid_in && active) begin
            shreg_d   = data_in;
            is_data_d = 1'b1;
          end else begin
            shreg_d   = COM;
            is_data_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out  = shreg_q[7];
    valid_out = is_data_q;
    sync_done = (state_q == DATA);
    load      = boundary && (state_q == DATA) && !reset;
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer: training, single byte, streaming,
// inactive link, mid-symbol reset, and a SYNC_SYMS=1 instance.
module tb_lane_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in, active;
  logic       load, data_out, valid_out, sync_done;

  logic       reset1;
  logic [7:0] data_in1;
  logic       valid_in1, active1;
  logic       load1, data_out1, valid_out1, sync_done1;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  logic [7:0] com = 8'hBC;

  always #5 clk = ~clk;

  lane_serializer #(.SYNC_SYMS(4), .COM(8'hBC)) dut (
    .clk_8f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .active(active), .load(load), .data_out(data_out),
    .valid_out(valid_out), .sync_done(sync_done)
  );

  lane_serializer #(.SYNC_SYMS(1), .COM(8'hBC)) dut1 (
    .clk_8f(clk), .reset(reset1), .data_in(data_in1), .valid_in(valid_in1),
    .active(active1), .load(load1), .data_out(data_out1),
    .valid_out(valid_out1), .sync_done(sync_done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
  endtask

  task automatic train();
    for (int i = 0; i < 32; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; active = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    checks += 4;
    if (data_out !== 1'b0) begin errors++; $display("FAIL reset data_out: got %b want 0", data_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset valid_out: got %b want 0", valid_out); end
    if (sync_done !== 1'b0) begin errors++; $display("FAIL reset sync_done: got %b want 0", sync_done); end
    if (load !== 1'b0) begin errors++; $display("FAIL reset load: got %b want 0", load); end
    valid_in = 1'b0;
  endtask

  task automatic test_training();
    logic exp_load;
    apply_reset();
    for (int e = 1; e <= 32; e++) begin
      tick();
      exp_load = (e % 8 == 0) && (e >= 25);
      checks += 4;
      if (data_out !== com[7 - ((e - 1) % 8)]) begin errors++;
        $display("FAIL train data_out edge %0d: got %b want %b", e, data_out, com[7 - ((e - 1) % 8)]); end
      if (valid_out !== 1'b0) begin errors++;
        $display("FAIL train valid_out edge %0d: got %b want 0", e, valid_out); end
      if (sync_done !== (e >= 25)) begin errors++;
        $display("FAIL train sync_done edge %0d: got %b want %b", e, sync_done, (e >= 25)); end
      if (load !== exp_load) begin errors++;
        $display("FAIL train load edge %0d: got %b want %b", e, load, exp_load); end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] b = 8'hEE;
    apply_reset();
    train();
    valid_in = 1'b1; data_in = b;
    for (int e = 33; e <= 41; e++) begin
      tick();
      valid_in = 1'b0; data_in = 8'h00;
      checks += 2;
      if (e <= 40) begin
        if (data_out !== b[7 - (e - 33)]) begin errors++;
          $display("FAIL single data_out edge %0d: got %b want %b", e, data_out, b[7 - (e - 33)]); end
        if (valid_out !== 1'b1) begin errors++;
          $display("FAIL single valid_out edge %0d: got %b want 1", e, valid_out); end
      end else begin
        if (data_out !== com[7]) begin errors++;
          $display("FAIL single com_after data_out: got %b want %b", data_out, com[7]); end
        if (valid_out !== 1'b0) begin errors++;
          $display("FAIL single com_after valid_out: got %b want 0", valid_out); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] strm [3] = '{8'hFF, 8'hCC, 8'hAA};
    logic [7:0] cur;
    apply_reset();
    train();
    for (int e = 33; e <= 57; e++) begin
      if ((e - 33) % 8 == 0) begin
        valid_in = (e < 57);
        data_in  = (e < 57) ? strm[(e - 33) / 8] : 8'h00;
      end
      tick();
      checks += 3;
      if (e <= 56) begin
        cur = strm[(e - 33) / 8];
        if (data_out !== cur[7 - ((e - 33) % 8)]) begin errors++;
          $display("FAIL stream data_out edge %0d: got %b want %b", e, data_out, cur[7 - ((e - 33) % 8)]); end
        if (valid_out !== 1'b1) begin errors++;
          $display("FAIL stream valid_out edge %0d: got %b want 1", e, valid_out); end
      end else begin
        if (data_out !== com[7]) begin errors++;
          $display("FAIL stream tail data_out: got %b want %b", data_out, com[7]); end
        if (valid_out !== 1'b0) begin errors++;
          $display("FAIL stream tail valid_out: got %b want 0", valid_out); end
      end
      if (load !== (e % 8 == 0)) begin errors++;
        $display("FAIL stream load edge %0d: got %b want %b", e, load, (e % 8 == 0)); end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_inactive();
    logic [7:0] b = 8'h34;
    apply_reset();
    train();
    for (int e = 33; e <= 40; e++) tick();
    active = 1'b0; valid_in = 1'b1; data_in = 8'h12;
    for (int e = 41; e <= 48; e++) begin
      tick();
      checks += 3;
      if (data_out !== com[7 - (e - 41)]) begin errors++;
        $display("FAIL inactive data_out edge %0d: got %b want %b", e, data_out, com[7 - (e - 41)]); end
      if (valid_out !== 1'b0) begin errors++;
        $display("FAIL inactive valid_out edge %0d: got %b want 0", e, valid_out); end
      if (sync_done !== 1'b1) begin errors++;
        $display("FAIL inactive sync_done edge %0d: got %b want 1", e, sync_done); end
    end
    checks++;
    if (load !== 1'b1) begin errors++; $display("FAIL inactive load edge 48: got %b want 1", load); end
    active = 1'b1; data_in = b;
    for (int e = 49; e <= 56; e++) begin
      tick();
      valid_in = 1'b0;
      checks += 2;
      if (data_out !== b[7 - (e - 49)]) begin errors++;
        $display("FAIL reactivate data_out edge %0d: got %b want %b", e, data_out, b[7 - (e - 49)]); end
      if (valid_out !== 1'b1) begin errors++;
        $display("FAIL reactivate valid_out edge %0d: got %b want 1", e, valid_out); end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b = 8'h56;
    apply_reset();
    train();
    valid_in = 1'b1; data_in = b;
    for (int e = 33; e <= 35; e++) begin
      tick();
      checks++;
      if (data_out !== b[7 - (e - 33)]) begin errors++;
        $display("FAIL midrst pre data_out edge %0d: got %b want %b", e, data_out, b[7 - (e - 33)]); end
    end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (data_out !== 1'b0) begin errors++; $display("FAIL midrst data_out: got %b want 0", data_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst valid_out: got %b want 0", valid_out); end
    if (sync_done !== 1'b0) begin errors++; $display("FAIL midrst sync_done: got %b want 0", sync_done); end
    if (load !== 1'b0) begin errors++; $display("FAIL midrst load: got %b want 0", load); end
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks += 2;
      if (e <= 32) begin
        if (data_out !== com[7 - ((e - 1) % 8)]) begin errors++;
          $display("FAIL midrst retrain data_out edge %0d: got %b want %b", e, data_out, com[7 - ((e - 1) % 8)]); end
        if (valid_out !== 1'b0) begin errors++;
          $display("FAIL midrst retrain valid_out edge %0d: got %b want 0", e, valid_out); end
      end else begin
        if (data_out !== b[7 - (e - 33)]) begin errors++;
          $display("FAIL midrst data data_out edge %0d: got %b want %b", e, data_out, b[7 - (e - 33)]); end
        if (valid_out !== 1'b1) begin errors++;
          $display("FAIL midrst data valid_out edge %0d: got %b want 1", e, valid_out); end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_sync_one();
    logic [7:0] b = 8'hA5;
    @(negedge clk);
    checks++;
    if (data_out1 !== 1'b0) begin errors++; $display("FAIL sync1 reset data_out: got %b want 0", data_out1); end
    reset1 = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks += 2;
      if (sync_done1 !== 1'b1) begin errors++;
        $display("FAIL sync1 sync_done edge %0d: got %b want 1", e, sync_done1); end
      if (load1 !== (e == 8)) begin errors++;
        $display("FAIL sync1 load edge %0d: got %b want %b", e, load1, (e == 8)); end
    end
    valid_in1 = 1'b1; data_in1 = b;
    for (int e = 9; e <= 16; e++) begin
      tick();
      valid_in1 = 1'b0;
      checks += 2;
      if (data_out1 !== b[7 - (e - 9)]) begin errors++;
        $display("FAIL sync1 data_out edge %0d: got %b want %b", e, data_out1, b[7 - (e - 9)]); end
      if (valid_out1 !== 1'b1) begin errors++;
        $display("FAIL sync1 valid_out edge %0d: got %b want 1", e, valid_out1); end
    end
  endtask

  initial begin
    reset1 = 1'b1; valid_in1 = 1'b1; data_in1 = 8'h77; active1 = 1'b1;
    test_reset();
    test_training();
    test_single_byte();
    test_back_to_back();
    test_inactive();
    test_mid_reset();
    test_sync_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
